// File: rtl/detection_collector.sv
// detection_collector: turns the per-window classifier result stream into a FIFO of (x, y, scale) detection records
package detection_collector_pkg;
  function automatic int scaled_dim(input int base, input int s, input int q8);
    int d;
    d = base;
    for (int i = 0; i < s; i++) d = d * 256 / q8;
    return d;
  endfunction
  function automatic int active_scales(input int iw, input int ih, input int fw, input int fh, input int sn, input int q8);
    int n;
    n = 0;
    for (int s = 0; s < sn; s++)
      if (n == s && scaled_dim(iw, s, q8) >= fw && scaled_dim(ih, s, q8) >= fh) n++;
    return n;
  endfunction
  function automatic int total_windows(input int iw, input int ih, input int fw, input int fh, input int sn, input int q8);
    int t;
    t = 0;
    for (int s = 0; s < active_scales(iw, ih, fw, fh, sn, q8); s++)
      t += (scaled_dim(iw, s, q8) - fw + 1) * (scaled_dim(ih, s, q8) - fh + 1);
    return t;
  endfunction
endpackage

module detection_collector import detection_collector_pkg::*; #(
  parameter int IMG_WIDTH = 45,
  parameter int IMG_HEIGHT = 45,
  parameter int FEATURE_WIDTH = 25,
  parameter int FEATURE_HEIGHT = 25,
  parameter int SCALE_NUM = 2,
  parameter int SCALE_FACTOR_Q8 = 320,
  parameter int DET_FIFO_DEPTH = 4,
  localparam int W_X = $clog2(IMG_WIDTH),
  localparam int W_Y = $clog2(IMG_HEIGHT),
  localparam int W_S = SCALE_NUM > 1 ? $clog2(SCALE_NUM) : 1,
  localparam int W_CNT = $clog2(total_windows(IMG_WIDTH, IMG_HEIGHT, FEATURE_WIDTH, FEATURE_HEIGHT, SCALE_NUM, SCALE_FACTOR_Q8) + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             result_valid,
  output logic             result_ready,
  input  logic             result_data,
  output logic             det_valid,
  input  logic             det_ready,
  output logic [W_X-1:0]   det_x,
  output logic [W_Y-1:0]   det_y,
  output logic [W_S-1:0]   det_scale,
  output logic [W_CNT-1:0] det_count,
  output logic             frame_done
);
  localparam int N_ACT = active_scales(IMG_WIDTH, IMG_HEIGHT, FEATURE_WIDTH, FEATURE_HEIGHT, SCALE_NUM, SCALE_FACTOR_Q8);
  localparam int W_P = $clog2(DET_FIFO_DEPTH);
  localparam int W_R = W_X + W_Y + W_S;
  logic [W_X-1:0] x, x_max;
  logic [W_Y-1:0] y, y_max;
  logic [W_S-1:0] scale;
  logic [W_X-1:0] x_max_t [2**W_S];
  logic [W_Y-1:0] y_max_t [2**W_S];
  logic [W_R-1:0] mem [DET_FIFO_DEPTH];
  logic [W_P-1:0] wr, rd;
  logic [W_P:0] occ;
  logic rst_q, new_frame, accept, push, pop, full, x_end, y_end, s_end, last_win;
  for (genvar s = 0; s < 2**W_S; s++) begin : g_geom
    assign x_max_t[s] = W_X'(scaled_dim(IMG_WIDTH, s, SCALE_FACTOR_Q8) - FEATURE_WIDTH);
    assign y_max_t[s] = W_Y'(scaled_dim(IMG_HEIGHT, s, SCALE_FACTOR_Q8) - FEATURE_HEIGHT);
  end
  assign x_max = x_max_t[scale];
  assign y_max = y_max_t[scale];
  assign x_end = x == x_max;
  assign y_end = y == y_max;
  assign s_end = scale == W_S'(N_ACT - 1);
  assign last_win = x_end & y_end & s_end;
  assign full = occ == (W_P+1)'(DET_FIFO_DEPTH);
  assign result_ready = !rst_q & !full;
  assign accept = result_valid & result_ready;
  assign push = accept & result_data;
  assign det_valid = occ != '0;
  assign pop = det_valid & det_ready;
  assign {det_x, det_y, det_scale} = det_valid ? mem[rd] : '0;
  // hold result_ready low for one cycle after reset releases
  always_ff @(posedge clk) rst_q <= rst;
  // advance the scan position on each accepted result and count positives per frame
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
      scale <= '0;
      det_count <= '0;
      frame_done <= 1'b0;
      new_frame <= 1'b1;
    end else begin
      frame_done <= accept & last_win;
      if (accept) begin
        x <= x_end ? '0 : x + W_X'(1);
        y <= x_end ? (y_end ? '0 : y + W_Y'(1)) : y;
        scale <= x_end & y_end ? (s_end ? '0 : scale + W_S'(1)) : scale;
        det_count <= (new_frame ? '0 : det_count) + W_CNT'(result_data);
        new_frame <= last_win;
      end
    end
  end
  // record FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
      occ <= '0;
    end else begin
      wr <= wr + W_P'(push);
      rd <= rd + W_P'(pop);
      occ <= occ + (W_P+1)'(push) - (W_P+1)'(pop);
    end
  end
  // record storage, written with the position of the accepted positive window
  always_ff @(posedge clk) if (push) mem[wr] <= {x, y, scale};
endmodule

// File: tb/tb_detection_collector.sv
// tb_detection_collector: randomized and directed checks of detection_collector against a window-index reference model
module tb_detection_collector;
  logic clk = 0, rst = 1, result_valid = 0, result_data = 0, det_ready = 0;
  logic result_ready, det_valid, frame_done;
  logic [5:0] det_x, det_y;
  logic [0:0] det_scale;
  logic [9:0] det_count;
  logic [31:0] dut_key;
  int total = 0, bad = 0;
  int q[$];
  int idx = 0, cnt = 0, acc_n = 0, frames = 0;
  bit fresh = 1;
  detection_collector dut (
    .clk(clk), .rst(rst), .result_valid(result_valid), .result_ready(result_ready),
    .result_data(result_data), .det_valid(det_valid), .det_ready(det_ready),
    .det_x(det_x), .det_y(det_y), .det_scale(det_scale), .det_count(det_count), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  assign dut_key = {10'd0, det_x, 2'd0, det_y, 7'd0, det_scale};
  // per-scale geometry: 45x45 image, 25x25 window, downscale by 256/320 for the second scale
  function automatic int nwin(input int s, input bit col);
    int d;
    d = 45;
    for (int i = 0; i < s; i++) d = d * 256 / 320;
    return col ? d - 25 + 1 : d - 25 + 1;
  endfunction
  function automatic int frame_total();
    return nwin(0, 1) * nwin(0, 0) + nwin(1, 1) * nwin(1, 0);
  endfunction
  function automatic int key_of(input int i);
    int nx, ny;
    for (int s = 0; s < 2; s++) begin
      nx = nwin(s, 1);
      ny = nwin(s, 0);
      if (i < nx * ny) return ((i % nx) << 16) | ((i / nx) << 8) | s;
      i -= nx * ny;
    end
    return -1;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic v, input logic d, input logic r);
    bit acc, pop, last;
    result_valid = v;
    result_data = d;
    det_ready = r;
    chk("ready", result_ready, q.size() < 4);
    acc = v & result_ready;
    pop = det_valid & r;
    last = 0;
    if (pop) chk("record", dut_key, q.pop_front());
    if (acc) begin
      if (d) q.push_back(key_of(idx));
      cnt = fresh ? int'(d) : cnt + int'(d);
      last = idx == frame_total() - 1;
      idx = last ? 0 : idx + 1;
      fresh = last;
      acc_n++;
      frames += int'(last);
    end
    @(posedge clk);
    #1;
    chk("frame_done", frame_done, acc && last);
    chk("det_count", det_count, cnt);
    chk("det_valid", det_valid, q.size() != 0);
  endtask
  task automatic do_reset();
    rst = 1;
    result_valid = 0;
    det_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", result_ready, 0);
    chk("rst_det_valid", det_valid, 0);
    chk("rst_count", det_count, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_record", dut_key, 0);
    rst = 0;
    @(posedge clk);
    #1;
    q.delete();
    idx = 0;
    cnt = 0;
    fresh = 1;
  endtask
  initial begin
    int start, budget;
    chk("frame_total", frame_total(), 585);
    do_reset();
    for (int i = 0; i < 585; i++) step(1, 0, 1);
    chk("t1_frames", frames, 1);
    for (int i = 0; i < 585; i++) step(1, i == 22 || i == 441 || i == 584, 1);
    step(0, 0, 1);
    chk("t2_count", det_count, 3);
    for (int i = 0; i < 8; i++) step(1, 1, 0);
    chk("t3_stall", result_ready, 0);
    chk("t3_accepts", idx, 4);
    budget = 0;
    while (idx < 5 && budget < 20) begin
      step(1, 1, 1);
      budget++;
    end
    chk("t3_fifth", idx, 5);
    repeat (8) step(0, 0, 1);
    start = acc_n;
    budget = 0;
    while (acc_n - start < 100 && budget < 1000) begin
      step(1, $urandom % 4 == 0, $urandom % 2);
      budget++;
    end
    chk("t4_accepts", acc_n - start, 100);
    do_reset();
    step(1, 1, 0);
    chk("t4_first", dut_key, 0);
    chk("t4_valid", det_valid, 1);
    repeat (3) step(0, 0, 1);
    for (int i = 1; i < 585; i++) step(1, i == 5 || i == 300, 1);
    repeat (3) step(0, 0, 1);
    chk("t5_hold", det_count, 3);
    for (int i = 0; i < 585; i++) step(1, i == 7 || i == 400, 1);
    repeat (3) step(0, 0, 1);
    chk("t5_frame1", det_count, 2);
    for (int i = 0; i < 20; i++) step(1, i == 10, 1);
    chk("t5_frame2", det_count, 1);
    start = frames;
    budget = 0;
    while (frames - start < 3 && budget < 20000) begin
      step($urandom % 2, $urandom % 2, $urandom % 2);
      budget++;
    end
    chk("t6_frames", frames - start, 3);
    budget = 0;
    while (q.size() != 0 && budget < 20) begin
      step(0, 0, 1);
      budget++;
    end
    chk("t6_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
